// File: rtl/aemb2_arb_pkg.sv
// Shared encodings for the AEMB2 instruction/data Wishbone arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aemb2_arb_pkg;

    // Arbiter FSM states; the encoding doubles as the grant code.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam int STV_W = 4;
    localparam int TMO_W = 8;

endpackage

// File: rtl/aemb2_arb_tmo.sv
// Stall watchdog: counts granted strobe cycles without ack, pulses tmo on the TMO-th.
// Latency: tmo is combinational in the stalled cycle that reaches the limit.
// Backpressure: none; the counter clears on ack, on timeout and whenever nobody owns the bus.
module aemb2_arb_tmo
    import aemb2_arb_pkg::*;
#(
    parameter int TMO = 255
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic stb,
    input  logic ack,
    output logic tmo
);

    logic [TMO_W-1:0] cnt;

    assign tmo = busy && stb && !ack && (cnt == TMO_W'(TMO - 1));

    // Stall counter: advance on each unacknowledged strobe cycle of the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!busy || ack || tmo) begin
            cnt <= '0;
        end else if (stb) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/aemb2_wb_arb.sv
// Two-master (iwb/dwb) to one-slave Wishbone classic arbiter; data wins, a starvation counter guarantees fetch progress.
// Latency: 1 cycle from a strobe sampled in IDLE to swb_stb_o; bus signals are muxed combinationally from the grant register.
// Backpressure: grant held while the owner's cyc is high; the other master waits until IDLE. Optional AEMB_ARB_TIMEOUT_EN aborts stalled transfers.
module aemb2_wb_arb
    import aemb2_arb_pkg::*;
#(
    parameter int AEMB_AW  = 18,
    parameter int AEMB_STV = 4,
    parameter int AEMB_TMO = 255
)
(
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,

    input  logic [AEMB_AW-1:2]   iwb_adr_i,
    input  logic                 iwb_stb_i,
    input  logic                 iwb_cyc_i,
    input  logic                 iwb_wre_i,
    input  logic [3:0]           iwb_sel_i,
    output logic [31:0]          iwb_dat_o,
    output logic                 iwb_ack_o,

    input  logic [AEMB_AW-1:2]   dwb_adr_i,
    input  logic                 dwb_stb_i,
    input  logic                 dwb_cyc_i,
    input  logic                 dwb_wre_i,
    input  logic [3:0]           dwb_sel_i,
    input  logic [31:0]          dwb_dat_i,
    output logic [31:0]          dwb_dat_o,
    output logic                 dwb_ack_o,

    output logic [AEMB_AW-1:2]   swb_adr_o,
    output logic                 swb_stb_o,
    output logic                 swb_cyc_o,
    output logic                 swb_wre_o,
    output logic [3:0]           swb_sel_o,
    output logic [31:0]          swb_dat_o,
    input  logic [31:0]          swb_dat_i,
    input  logic                 swb_ack_i,

    output logic [1:0]           arb_gnt_o,
    output logic                 arb_tmo_o
);

    // Reject out-of-range configurations at elaboration.
    if (AEMB_STV < 1 || AEMB_STV > 15 || AEMB_TMO < 1 || AEMB_TMO > 255) begin : g_bad_cfg
        $error("aemb2_wb_arb: AEMB_STV must be 1..15 and AEMB_TMO 1..255");
    end

    state_t           state;
    state_t           state_nxt;
    logic [STV_W-1:0] stv_cnt;
    logic             tmo;
    logic             d_wins;

    // Data wins unless fetch is pending and has already been passed over AEMB_STV times.
    assign d_wins = dwb_stb_i && (!iwb_stb_i || (stv_cnt < STV_W'(AEMB_STV)));

`ifdef AEMB_ARB_TIMEOUT_EN
    logic own_stb;
    assign own_stb = (state == ST_GNT_I) ? iwb_stb_i :
                     (state == ST_GNT_D) ? dwb_stb_i : 1'b0;

    aemb2_arb_tmo #(
        .TMO   (AEMB_TMO)
    ) u_tmo (
        .clk   (sys_clk_i),
        .rst_n (sys_rst_i),
        .busy  (state != ST_IDLE),
        .stb   (own_stb),
        .ack   (swb_ack_i),
        .tmo   (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    assign arb_tmo_o = tmo;

    // Grant register.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next grant: arbitrate only from IDLE; owners keep the bus until cyc falls or a timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (d_wins) begin
                    state_nxt = ST_GNT_D;
                end else if (iwb_stb_i) begin
                    state_nxt = ST_GNT_I;
                end
            end
            ST_GNT_I: if (!iwb_cyc_i || tmo) state_nxt = ST_IDLE;
            ST_GNT_D: if (!dwb_cyc_i || tmo) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Starvation counter: count data wins over a waiting fetch, clear when fetch gets the bus.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            stv_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (state_nxt == ST_GNT_I) begin
                stv_cnt <= '0;
            end else if (state_nxt == ST_GNT_D && iwb_stb_i && stv_cnt < STV_W'(AEMB_STV)) begin
                stv_cnt <= stv_cnt + STV_W'(1);
            end
        end
    end

    // Bus mux driven from the grant register; everything idles at zero when nobody owns the bus.
    always_comb begin
        swb_adr_o = '0;
        swb_stb_o = 1'b0;
        swb_cyc_o = 1'b0;
        swb_wre_o = 1'b0;
        swb_sel_o = 4'h0;
        swb_dat_o = 32'h0;
        iwb_ack_o = 1'b0;
        dwb_ack_o = 1'b0;
        iwb_dat_o = tmo ? 32'h0 : swb_dat_i;
        dwb_dat_o = tmo ? 32'h0 : swb_dat_i;
        arb_gnt_o = GNT_NONE;
        case (state)
            ST_GNT_I: begin
                swb_adr_o = iwb_adr_i;
                swb_stb_o = iwb_stb_i && !tmo;
                swb_cyc_o = iwb_cyc_i;
                swb_wre_o = iwb_wre_i;
                swb_sel_o = iwb_sel_i;
                iwb_ack_o = swb_ack_i || tmo;
                arb_gnt_o = GNT_I;
            end
            ST_GNT_D: begin
                swb_adr_o = dwb_adr_i;
                swb_stb_o = dwb_stb_i && !tmo;
                swb_cyc_o = dwb_cyc_i;
                swb_wre_o = dwb_wre_i;
                swb_sel_o = dwb_sel_i;
                swb_dat_o = dwb_dat_i;
                dwb_ack_o = swb_ack_i || tmo;
                arb_gnt_o = GNT_D;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aemb2_wb_arb.sv
// Directed bench for aemb2_wb_arb: reset, single fetch, starvation rotation, data write, async reset, abandon, timeout.
// Latency: expects a 1-cycle grant after a strobe is sampled in IDLE.
// Backpressure: slave acks are driven per-cycle by the stimulus.
module tb_aemb2_wb_arb;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:2] iwb_adr, dwb_adr, swb_adr;
    logic          iwb_stb, iwb_cyc, iwb_wre, dwb_stb, dwb_cyc, dwb_wre;
    logic [3:0]    iwb_sel, dwb_sel, swb_sel;
    logic [31:0]   dwb_wdat, iwb_rdat, dwb_rdat, swb_wdat, swb_rdat;
    logic          iwb_ack, dwb_ack, swb_stb, swb_cyc, swb_wre, swb_ack;
    logic [1:0]    gnt;
    logic          tmo;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_seq [10];

    always #5 clk = ~clk;

    aemb2_wb_arb #(
        .AEMB_AW  (AW),
        .AEMB_STV (4),
        .AEMB_TMO (8)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst_n),
        .iwb_adr_i (iwb_adr),
        .iwb_stb_i (iwb_stb),
        .iwb_cyc_i (iwb_cyc),
        .iwb_wre_i (iwb_wre),
        .iwb_sel_i (iwb_sel),
        .iwb_dat_o (iwb_rdat),
        .iwb_ack_o (iwb_ack),
        .dwb_adr_i (dwb_adr),
        .dwb_stb_i (dwb_stb),
        .dwb_cyc_i (dwb_cyc),
        .dwb_wre_i (dwb_wre),
        .dwb_sel_i (dwb_sel),
        .dwb_dat_i (dwb_wdat),
        .dwb_dat_o (dwb_rdat),
        .dwb_ack_o (dwb_ack),
        .swb_adr_o (swb_adr),
        .swb_stb_o (swb_stb),
        .swb_cyc_o (swb_cyc),
        .swb_wre_o (swb_wre),
        .swb_sel_o (swb_sel),
        .swb_dat_o (swb_wdat),
        .swb_dat_i (swb_rdat),
        .swb_ack_i (swb_ack),
        .arb_gnt_o (gnt),
        .arb_tmo_o (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        iwb_adr = '0; iwb_stb = 0; iwb_cyc = 0; iwb_wre = 0; iwb_sel = 4'h0;
        dwb_adr = '0; dwb_stb = 0; dwb_cyc = 0; dwb_wre = 0; dwb_sel = 4'h0;
        dwb_wdat = 32'h0; swb_rdat = 32'h0; swb_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_all();
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_i;
        int acks_d;
        exp_seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

        // Reset with a live data request and a stray slave ack.
        rst_n = 0;
        idle_all();
        dwb_stb = 1; dwb_cyc = 1; dwb_wre = 1; dwb_sel = 4'hF;
        dwb_adr = 16'h1234; dwb_wdat = 32'hCAFEF00D; swb_ack = 1;
        tick();
        tick();
        chk("rst_stb", swb_stb, 0);
        chk("rst_cyc", swb_cyc, 0);
        chk("rst_wre", swb_wre, 0);
        chk("rst_sel", swb_sel, 0);
        chk("rst_adr", swb_adr, 0);
        chk("rst_dat", swb_wdat, 0);
        chk("rst_dack", dwb_ack, 0);
        chk("rst_iack", iwb_ack, 0);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_tmo", tmo, 0);
        swb_ack = 0;
        rst_n = 1;
        #1;
        chk("rel_gnt_pre", gnt, 2'b00);
        tick();
        chk("rel_gnt", gnt, 2'b10);
        chk("rel_stb", swb_stb, 1);
        chk("rel_adr", swb_adr, 16'h1234);

        // Single instruction read, slave acks on the third granted cycle.
        do_reset();
        iwb_adr = 16'h0040; iwb_sel = 4'hF; iwb_stb = 1; iwb_cyc = 1;
        tick();
        chk("ird_gnt", gnt, 2'b01);
        chk("ird_adr", swb_adr, 16'h0040);
        acks_i = 0;
        acks_d = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                swb_ack = 1; swb_rdat = 32'hB8000000;
            end else begin
                swb_ack = 0; swb_rdat = 32'h0BADF00D;
            end
            #1;
            if (iwb_ack) begin
                acks_i++;
                chk("ird_dat", iwb_rdat, 32'hB8000000);
            end
            if (dwb_ack) acks_d++;
            tick();
            if (c == 2) begin
                iwb_stb = 0; iwb_cyc = 0;
            end
        end
        chk("ird_iack_cnt", acks_i, 1);
        chk("ird_dack_cnt", acks_d, 0);
        chk("ird_end_gnt", gnt, 2'b00);

        // Continuous competing requests: starvation limit forces every fifth grant to fetch.
        do_reset();
        iwb_stb = 1; iwb_cyc = 1; dwb_stb = 1; dwb_cyc = 1;
        for (int k = 0; k < 10; k++) begin
            int w;
            logic [1:0] g;
            w = 0;
            tick();
            while (gnt == 2'b00 && w < 20) begin
                tick();
                w++;
            end
            g = gnt;
            chk($sformatf("alt_gnt%0d", k), g, exp_seq[k]);
            swb_ack = 1;
            #1;
            chk($sformatf("alt_nack%0d", k), (g == 2'b10) ? iwb_ack : dwb_ack, 0);
            tick();
            swb_ack = 0;
            if (g == 2'b10) begin
                dwb_stb = 0; dwb_cyc = 0;
            end else begin
                iwb_stb = 0; iwb_cyc = 0;
            end
            tick();
            iwb_stb = 1; iwb_cyc = 1; dwb_stb = 1; dwb_cyc = 1;
        end

        // Data write while a fetch is pending; fetch follows once dwb releases cyc.
        do_reset();
        iwb_adr = 16'h0100; iwb_sel = 4'hF; iwb_stb = 1; iwb_cyc = 1;
        dwb_adr = 16'h0200; dwb_wre = 1; dwb_sel = 4'h3; dwb_wdat = 32'h1234ABCD;
        dwb_stb = 1; dwb_cyc = 1;
        tick();
        chk("dwr_gnt", gnt, 2'b10);
        chk("dwr_dat", swb_wdat, 32'h1234ABCD);
        chk("dwr_sel", swb_sel, 4'h3);
        chk("dwr_wre", swb_wre, 1);
        chk("dwr_adr", swb_adr, 16'h0200);
        swb_ack = 1;
        #1;
        chk("dwr_dack", dwb_ack, 1);
        chk("dwr_iack", iwb_ack, 0);
        tick();
        swb_ack = 0; dwb_stb = 0; dwb_cyc = 0; dwb_wre = 0;
        tick();
        chk("dwr_idle", gnt, 2'b00);
        tick();
        chk("dwr_ignt", gnt, 2'b01);
        chk("dwr_iadr", swb_adr, 16'h0100);
        chk("dwr_idat", swb_wdat, 32'h0);

        // Asynchronous reset in the middle of a data transfer awaiting ack.
        do_reset();
        dwb_adr = 16'h0333; dwb_sel = 4'hF; dwb_stb = 1; dwb_cyc = 1;
        tick();
        chk("art_gnt", gnt, 2'b10);
        tick();
        chk("art_stb", swb_stb, 1);
        #2;
        rst_n = 0;
        #1;
        chk("art_stb0", swb_stb, 0);
        chk("art_cyc0", swb_cyc, 0);
        chk("art_adr0", swb_adr, 0);
        chk("art_gnt0", gnt, 2'b00);
        swb_ack = 1;
        #1;
        chk("art_dack0", dwb_ack, 0);
        tick();
        swb_ack = 0;
        rst_n = 1;
        #1;
        chk("art_rel_gnt", gnt, 2'b00);
        tick();
        chk("art_regnt", gnt, 2'b10);

        // Owner abandons strobe without ack: grant holds until cyc falls; acks in IDLE are ignored.
        dwb_stb = 0;
        tick();
        chk("abn_hold", gnt, 2'b10);
        chk("abn_stb", swb_stb, 0);
        dwb_cyc = 0;
        tick();
        chk("abn_idle", gnt, 2'b00);
        swb_ack = 1;
        #1;
        chk("idle_iack", iwb_ack, 0);
        chk("idle_dack", dwb_ack, 0);
        swb_ack = 0;

`ifdef AEMB_ARB_TIMEOUT_EN
        // Slave never acks: forced ack and timeout pulse on the eighth stalled cycle.
        do_reset();
        dwb_adr = 16'h0077; dwb_sel = 4'hF; dwb_stb = 1; dwb_cyc = 1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("tmo_pulse%0d", c), tmo, (c == 8));
            chk($sformatf("tmo_dack%0d", c), dwb_ack, (c == 8));
            chk($sformatf("tmo_stb%0d", c), swb_stb, (c != 8));
            tick();
        end
        chk("tmo_idle", gnt, 2'b00);
        chk("tmo_clr", tmo, 0);
        dwb_stb = 0; dwb_cyc = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
